// File: rtl/servisia_pkg.sv
// Shared constants and types for the servisia memory and its serial program loader.
package servisia_pkg;

  localparam int AW_DEFAULT = 20;
  localparam int BYTE_W     = 8;
  localparam int BIT_CNT_W  = 3;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    PORT_CORE   = 1'b0,
    PORT_LOADER = 1'b1
  } port_owner_e;

  // Serial bytes arrive LSB first, so each new bit enters at the top and moves down.
  function automatic byte_t shift_in_lsb_first(input byte_t cur, input logic b);
    return {b, cur[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/servisia_mem_loader_if.sv
// Core-side memory bus: one muxed byte address, write and read strobes, registered read data.
interface servisia_mem_loader_if
  import servisia_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) ();

  logic [AW-1:0] addr;
  logic          write;
  byte_t         wdata;
  logic          read;
  byte_t         rdata;

  modport master (output addr, output write, output wdata, output read, input rdata);
  modport slave  (input addr, input write, input wdata, input read, output rdata);

endinterface

// File: rtl/servisia_mem_array.sv
// Byte-wide storage with one write port and one registered read port; contents survive reset.
module servisia_mem_array
  import servisia_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  byte_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output byte_t         rdata_o
);

  localparam int DEPTH = 1 << AW;

  byte_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read data holds its value in every cycle without an accepted read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/servisia_mem_loader.sv
// Program memory with a serial loader that owns the write port and holds the core in reset while load_en_i is high.
module servisia_mem_loader
  import servisia_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  servisia_mem_loader_if.slave  bus,
  input  logic                  load_en_i,
  input  logic                  load_valid_i,
  input  logic                  load_bit_i,
  output logic                  core_rst_no,
  output logic [AW-1:0]         load_addr_o
);

  logic                 load_en_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  byte_t                shift_q;

  logic                 load_start;
  logic                 load_take;
  logic                 byte_done;
  logic [BIT_CNT_W-1:0] cnt_base;
  logic [AW-1:0]        addr_base;
  byte_t                shift_next;
  port_owner_e          owner;

  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  byte_t                mem_wdata;
  logic                 mem_re;

  // A fresh load session restarts from byte 0, even if a bit arrives in its very first cycle.
  always_comb begin
    load_start = load_en_i & ~load_en_q;
    cnt_base   = load_start ? '0 : bit_cnt_q;
    addr_base  = load_start ? '0 : load_addr_o;
    load_take  = load_en_i & load_valid_i;
    shift_next = shift_in_lsb_first(shift_q, load_bit_i);
    byte_done  = load_take & (cnt_base == LAST_BIT);
    owner      = load_en_i ? PORT_LOADER : PORT_CORE;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.wdata;
    mem_re    = 1'b0;
    if (owner == PORT_LOADER) begin
      mem_we    = byte_done;
      mem_waddr = addr_base;
      mem_wdata = shift_next;
    end else begin
      mem_we    = bus.write;
      mem_re    = bus.read & ~bus.write;
    end
  end

  // A partially shifted byte is simply abandoned when load_en_i drops; the next session clears the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_en_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      load_addr_o <= '0;
      core_rst_no <= 1'b0;
    end else begin
      load_en_q   <= load_en_i;
      core_rst_no <= ~load_en_i;
      if (load_start) begin
        bit_cnt_q   <= '0;
        load_addr_o <= '0;
      end
      if (load_take) begin
        shift_q   <= shift_next;
        bit_cnt_q <= cnt_base + BIT_CNT_W'(1);
        if (byte_done) begin
          load_addr_o <= addr_base + AW'(1);
        end
      end
    end
  end

  servisia_mem_array #(
    .AW (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (bus.addr),
    .rdata_o (bus.rdata)
  );

endmodule
